// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage with a credit-limited prefetch queue feeding the FD boundary.
// Stale responses are counted off after a redirect instead of being tagged.
module fetch_prefetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic        IMEM_REQ_VALID,
   input  logic        IMEM_REQ_READY,
   output logic [31:0] IMEM_REQ_ADDR,
   input  logic        IMEM_RSP_VALID,
   input  logic [31:0] IMEM_RSP_DATA,
   output logic        FD_VALID,
   output logic [31:0] FD_PC,
   output logic [31:0] FD_IR,
   input  logic        STALL,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [CW-1:0] occupancy;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [31:0]   q_pc [DEPTH];
   logic [31:0]   q_ir [DEPTH];

   logic [CW:0]   credit_used;
   logic          req_fire;
   logic          rsp_drop;
   logic          push;
   logic          pop;
   logic [31:0]   target_pc;

   always_comb begin
      credit_used    = {1'b0, occupancy} + {1'b0, outstanding};
      IMEM_REQ_VALID = !RESET && !REDIRECT && (credit_used < DEPTH_C);
      IMEM_REQ_ADDR  = fetch_pc;
      req_fire       = IMEM_REQ_VALID && IMEM_REQ_READY;
      rsp_drop       = IMEM_RSP_VALID && ((drop_cnt != '0) || REDIRECT);
      push           = IMEM_RSP_VALID && !rsp_drop;
      pop            = (occupancy != '0) && !STALL && !REDIRECT;
      target_pc      = {REDIRECT_PC[31:2], 2'b00};
   end

   always_comb begin
      FD_VALID = (occupancy != '0);
      FD_PC    = FD_VALID ? q_pc[head] : '0;
      FD_IR    = FD_VALID ? q_ir[head] : '0;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fetch_pc <= RESET_PC;
      end else if (REDIRECT) begin
         fetch_pc <= target_pc;
      end else if (req_fire) begin
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         outstanding <= '0;
      end else begin
         case ({req_fire, IMEM_RSP_VALID})
            2'b10:   outstanding <= outstanding + CNT_ONE;
            2'b01:   outstanding <= outstanding - CNT_ONE;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Everything still in flight after a redirect cycle belongs to the old path.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         drop_cnt <= '0;
      end else if (REDIRECT) begin
         drop_cnt <= IMEM_RSP_VALID ? (outstanding - CNT_ONE) : outstanding;
      end else if (IMEM_RSP_VALID && (drop_cnt != '0)) begin
         drop_cnt <= drop_cnt - CNT_ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         resp_pc <= RESET_PC;
      end else if (REDIRECT) begin
         resp_pc <= target_pc;
      end else if (push) begin
         resp_pc <= resp_pc + 32'd4;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET || REDIRECT) begin
         occupancy <= '0;
         head      <= '0;
         tail      <= '0;
      end else begin
         if (push) begin
            tail <= tail + PTR_ONE;
         end
         if (pop) begin
            head <= head + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + CNT_ONE;
            2'b01:   occupancy <= occupancy - CNT_ONE;
            default: occupancy <= occupancy;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         q_pc[tail] <= resp_pc;
         q_ir[tail] <= IMEM_RSP_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         assert ({1'b0, occupancy} <= DEPTH_C);
         assert (!(IMEM_RSP_VALID && (outstanding == '0)));
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit: an in-order variable-latency memory
// plus an epoch-tagged model of what decode should see.
module tb_fetch_prefetch_unit;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

   logic        CLK;
   logic        RESET;
   logic        IMEM_REQ_VALID;
   logic        IMEM_REQ_READY;
   logic [31:0] IMEM_REQ_ADDR;
   logic        IMEM_RSP_VALID;
   logic [31:0] IMEM_RSP_DATA;
   logic        FD_VALID;
   logic [31:0] FD_PC;
   logic [31:0] FD_IR;
   logic        STALL;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;

   fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) u_dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .IMEM_REQ_VALID (IMEM_REQ_VALID),
      .IMEM_REQ_READY (IMEM_REQ_READY),
      .IMEM_REQ_ADDR  (IMEM_REQ_ADDR),
      .IMEM_RSP_VALID (IMEM_RSP_VALID),
      .IMEM_RSP_DATA  (IMEM_RSP_DATA),
      .FD_VALID       (FD_VALID),
      .FD_PC          (FD_PC),
      .FD_IR          (FD_IR),
      .STALL          (STALL),
      .REDIRECT       (REDIRECT),
      .REDIRECT_PC    (REDIRECT_PC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      int unsigned epoch;
      int unsigned due;
   } req_t;

   req_t        pending[$];
   logic [31:0] dq[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;
   int unsigned epoch   = 0;
   int unsigned last_due = 0;
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;
   logic [31:0] exp_fetch = RPC;
   logic [31:0] exp_dec   = RPC;
   logic        obs_fd_valid;
   logic [31:0] obs_fd_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input logic rst, input logic rdy, input logic stl,
                       input logic redir, input logic [31:0] rpc);
      logic        rsp_v;
      logic [31:0] rsp_addr;
      logic        exp_req;
      logic        hs;
      logic        pop_now;
      logic        accept;
      int unsigned due;
      req_t        r;
      @(negedge CLK);
      if (rst) pending.delete();
      rsp_v    = 1'b0;
      rsp_addr = '0;
      if (pending.size() > 0 && pending[0].due == cyc) begin
         rsp_v    = 1'b1;
         rsp_addr = pending[0].addr;
      end
      RESET          = rst;
      IMEM_REQ_READY = rdy;
      STALL          = stl;
      REDIRECT       = redir;
      REDIRECT_PC    = rpc;
      IMEM_RSP_VALID = rsp_v;
      IMEM_RSP_DATA  = rsp_v ? mem_word(rsp_addr) : $urandom;
      #1;
      obs_fd_valid = FD_VALID;
      obs_fd_pc    = FD_PC;
      exp_req = !rst && !redir && ((dq.size() + pending.size()) < DEPTH);
      check("req_valid", {31'b0, IMEM_REQ_VALID}, {31'b0, exp_req});
      if (exp_req) check("req_addr", IMEM_REQ_ADDR, exp_fetch);
      check("fd_valid", {31'b0, FD_VALID}, (dq.size() > 0) ? 32'd1 : 32'd0);
      check("fd_pc", FD_PC, (dq.size() > 0) ? dq[0] : 32'd0);
      check("fd_ir", FD_IR, (dq.size() > 0) ? mem_word(dq[0]) : 32'd0);
      pop_now = !rst && !redir && !stl && (dq.size() > 0);
      if (pop_now) begin
         check("dec_stream", FD_PC, exp_dec);
         exp_dec = exp_dec + 32'd4;
      end
      hs = exp_req && rdy;

      if (rst) begin
         dq.delete();
         pending.delete();
         exp_fetch = RPC;
         exp_dec   = RPC;
         last_due  = 0;
         epoch++;
      end else begin
         accept = 1'b0;
         if (hs) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pending.push_back('{addr: exp_fetch, epoch: epoch, due: due});
            exp_fetch = exp_fetch + 32'd4;
         end
         if (rsp_v) begin
            r = pending.pop_front();
            accept = (r.epoch == epoch) && !redir;
         end
         if (redir) begin
            dq.delete();
            epoch++;
            exp_fetch = {rpc[31:2], 2'b00};
            exp_dec   = {rpc[31:2], 2'b00};
         end else begin
            if (pop_now) void'(dq.pop_front());
            if (accept) dq.push_back(r.addr);
         end
      end
      @(posedge CLK);
      cyc++;
   endtask

   initial begin
      int unsigned n;
      logic [31:0] tgt;
      RESET = 1'b1; IMEM_REQ_READY = 1'b0; STALL = 1'b0; REDIRECT = 1'b0;
      REDIRECT_PC = '0; IMEM_RSP_VALID = 1'b0; IMEM_RSP_DATA = '0;
      repeat (2) @(posedge CLK);

      // Streaming at L=1 from a reset PC that wraps through zero.
      lat_min = 1; lat_max = 1;
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      n = 0;
      do begin
         step(0, 1, 0, 0, 0);
         n++;
      end while (!obs_fd_valid && n < 10);
      check("s1_first_fd_cycle", n, 3);
      check("s1_first_fd_pc", obs_fd_pc, RPC);
      repeat (12) step(0, 1, 0, 0, 0);

      // Long stall fills the queue and exhausts credits.
      repeat (10) step(0, 1, 1, 0, 0);
      repeat (8) step(0, 1, 0, 0, 0);

      // L=3, redirect with three requests in flight.
      lat_min = 3; lat_max = 3;
      n = 0;
      while (pending.size() != 3 && n < 20) begin
         step(0, 1, 0, 0, 0);
         n++;
      end
      check("s3_inflight", pending.size(), 3);
      step(0, 1, 0, 1, 32'h0000_0103);
      n = 0;
      do begin
         step(0, 1, 0, 0, 0);
         n++;
      end while (!obs_fd_valid && n < 20);
      check("s3_first_fd_valid", {31'b0, obs_fd_valid}, 32'd1);
      check("s3_first_fd_pc", obs_fd_pc, 32'h0000_0100);
      repeat (6) step(0, 1, 0, 0, 0);

      // Redirect coinciding with a response and a poppable head.
      lat_min = 1; lat_max = 1;
      n = 0;
      while (!(dq.size() > 0 && pending.size() > 0 && pending[0].due == cyc) && n < 20) begin
         step(0, 1, 1, 0, 0);
         n++;
      end
      check("s4_setup", (dq.size() > 0 && pending.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      step(0, 1, 0, 1, 32'h0000_2000);
      step(0, 1, 0, 0, 0);
      check("s4_fd_after", {31'b0, obs_fd_valid}, 32'd0);
      repeat (6) step(0, 1, 0, 0, 0);

      // Randomized ready, latency, stall and occasional redirects.
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         tgt = $urandom;
         if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 | tgt[3:0];
         step(0, ($urandom_range(1, 0) == 1), ($urandom_range(9, 0) < 3),
              ($urandom_range(49, 0) == 0), tgt);
      end

      // Reset in the middle of a stream, then restart from RESET_PC.
      lat_min = 2; lat_max = 2;
      repeat (6) step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      check("s6_fd_after_reset", {31'b0, obs_fd_valid}, 32'd0);
      repeat (12) step(0, 1, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
